// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_pkg                                                    |
// | Description : Shared RV32I constants and fetch-state type for the pipeline|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_id_reg                                                    |
// | Description : IF/ID pipeline register with flush (to NOP), load and hold  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    // Flush outranks load; with neither asserted the register holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= 32'd0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_pc    <= 32'd0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : PC register, next-PC mux and RUN/HALTED fetch FSM           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        halted
);

    logic [31:0]  r_pc;
    fetch_state_t r_state;
    logic         w_load;
    logic         w_flush;
    logic         w_is_ecall;

    assign w_is_ecall = (imem_data == ECALL_INST);

    // Redirect always flushes; once halted, every unstalled edge inserts a bubble.
    assign w_flush = pc_src | (~stall & (r_state == HALTED));
    assign w_load  = ~pc_src & ~stall & (r_state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
        end else if (pc_src) begin
            r_pc    <= branch_target & ~32'd3;
            r_state <= RUN;
        end else if (!stall) begin
            case (r_state)
                RUN: begin
                    if (w_is_ecall) begin
                        r_state <= HALTED;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign halted    = (r_state == HALTED);

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_load  (w_load),
        .i_pc    (r_pc),
        .i_inst  (imem_data),
        .o_pc    (if_id_pc),
        .o_inst  (if_id_inst),
        .o_valid (if_id_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                               |
// | Description : Directed self-checking bench for fetch_stage                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] C_NOP   = 32'h0000_0013;
    localparam logic [31:0] C_ECALL = 32'h0000_0073;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
    logic        ecall_en;

    logic        rst2;
    logic        stall2;
    logic        pc_src2;
    logic [31:0] branch_target2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic [31:0] if_id_pc2;
    logic [31:0] if_id_inst2;
    logic        if_id_valid2;
    logic        halted2;

    int checks;
    int errors;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1234_5000;
    endfunction

    assign imem_data  = (ecall_en && imem_addr == 32'd12) ? C_ECALL : mem(imem_addr);
    assign imem_data2 = mem(imem_addr2);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_pc      (if_id_pc),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .stall         (stall2),
        .pc_src        (pc_src2),
        .branch_target (branch_target2),
        .imem_addr     (imem_addr2),
        .imem_data     (imem_data2),
        .if_id_pc      (if_id_pc2),
        .if_id_inst    (if_id_inst2),
        .if_id_valid   (if_id_valid2),
        .halted        (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'd0; ecall_en = 1'b0;
        rst2 = 1'b1; stall2 = 1'b0; pc_src2 = 1'b0; branch_target2 = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr",  imem_addr,   32'd0);
        chk("reset_inst",  if_id_inst,  C_NOP);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_pc",    if_id_pc,    32'd0);
        chk("reset_halt",  {31'd0, halted}, 32'd0);

        @(negedge clk) rst = 1'b0;
        step();
        chk("f0_pc",    if_id_pc,   32'd0);
        chk("f0_inst",  if_id_inst, mem(32'd0));
        chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
        chk("f0_addr",  imem_addr,  32'd4);
        step();
        chk("f1_pc",   if_id_pc,  32'd4);
        chk("f1_addr", imem_addr, 32'd8);

        // Stall three cycles with pc=8
        @(negedge clk) stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_pc",   if_id_pc,  32'd4);
            chk("stall_inst", if_id_inst, mem(32'd4));
        end
        @(negedge clk) stall = 1'b0;
        step();
        chk("unstall_pc0", if_id_pc, 32'd8);
        chk("unstall_in0", if_id_inst, mem(32'd8));
        step();
        chk("unstall_pc1", if_id_pc, 32'd12);
        chk("unstall_ad1", imem_addr, 32'd16);

        // Asynchronous mid-run reset, checked before any clock edge
        @(negedge clk) rst = 1'b1;
        #1;
        chk("areset_addr",  imem_addr,  32'd0);
        chk("areset_inst",  if_id_inst, C_NOP);
        chk("areset_valid", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("rf0_pc",   if_id_pc,   32'd0);
        chk("rf0_inst", if_id_inst, mem(32'd0));
        step();
        chk("rf1_pc",   if_id_pc,   32'd4);
        chk("rf1_inst", if_id_inst, mem(32'd4));
        step();
        chk("rf2_pc",   if_id_pc,   32'd8);
        chk("rf2_inst", if_id_inst, mem(32'd8));

        // Redirect wins over simultaneous stall; target low bits cleared
        @(negedge clk) begin pc_src = 1'b1; stall = 1'b1; branch_target = 32'h0000_0043; end
        step();
        chk("redir_addr",  imem_addr, 32'h40);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_inst",  if_id_inst, C_NOP);
        @(negedge clk) begin pc_src = 1'b0; stall = 1'b0; end
        step();
        chk("redir_pc",    if_id_pc,   32'h40);
        chk("redir_tinst", if_id_inst, mem(32'h40));
        chk("redir_next",  imem_addr,  32'h44);

        // ECALL at address 12, first met under a stall
        ecall_en = 1'b1;
        @(negedge clk) begin pc_src = 1'b1; branch_target = 32'd8; end
        step();
        chk("ec_redir", imem_addr, 32'd8);
        @(negedge clk) pc_src = 1'b0;
        step();
        chk("ec_pc8",  if_id_pc,  32'd8);
        chk("ec_ad12", imem_addr, 32'd12);
        @(negedge clk) stall = 1'b1;
        step();
        chk("ec_stall_halt", {31'd0, halted}, 32'd0);
        chk("ec_stall_pc",   if_id_pc, 32'd8);
        @(negedge clk) stall = 1'b0;
        step();
        chk("ec_inst",  if_id_inst, C_ECALL);
        chk("ec_pc",    if_id_pc,   32'd12);
        chk("ec_valid", {31'd0, if_id_valid}, 32'd1);
        chk("ec_halt",  {31'd0, halted}, 32'd1);
        chk("ec_addr",  imem_addr, 32'd12);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
            chk("halt_inst",  if_id_inst, C_NOP);
            chk("halt_addr",  imem_addr, 32'd12);
            chk("halt_flag",  {31'd0, halted}, 32'd1);
        end

        // Leave HALTED through a redirect
        @(negedge clk) begin pc_src = 1'b1; branch_target = 32'h100; end
        step();
        chk("exit_halt",  {31'd0, halted}, 32'd0);
        chk("exit_addr",  imem_addr, 32'h100);
        chk("exit_valid", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk) pc_src = 1'b0;
        step();
        chk("exit_pc",   if_id_pc,   32'h100);
        chk("exit_inst", if_id_inst, mem(32'h100));
        chk("exit_next", imem_addr,  32'h104);

        // PC wraps modulo 2^32
        @(negedge clk) rst2 = 1'b0;
        #1;
        chk("wrap_a0", imem_addr2, 32'hFFFF_FFF8);
        step();
        chk("wrap_a1", imem_addr2, 32'hFFFF_FFFC);
        chk("wrap_p1", if_id_pc2,  32'hFFFF_FFF8);
        step();
        chk("wrap_a2", imem_addr2, 32'h0000_0000);
        chk("wrap_p2", if_id_pc2,  32'hFFFF_FFFC);
        chk("wrap_i2", if_id_inst2, mem(32'hFFFF_FFFC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with PC register and IF/ID pipeline register. Drives the instruction-memory address, captures the returned instruction word, and presents `if_id_inst` and `if_id_pc` to decode, where the immediate generator and register file consume them. Handles hazard-unit stalls, taken-branch redirects with flush, and a halt on ECALL.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard-unit stall; freezes the PC and IF/ID register.
- `pc_src`  in  1: taken-branch redirect from a later stage.
- `branch_target`  in  32: redirect address, valid when `pc_src`=1.
- `imem_addr`  out  32: instruction-memory address; equals the PC register.
- `imem_data`  in  32: instruction word; asynchronous read of `imem_addr`, same cycle.
- `if_id_pc`  out  32: PC of the instruction in IF/ID.
- `if_id_inst`  out  32: instruction in IF/ID; NOP when the slot is invalid.
- `if_id_valid`  out  1: IF/ID holds a real instruction.
- `halted`  out  1: fetch FSM is in HALTED.

## Operation
- State: `pc`, `if_id_pc`, `if_id_inst`, `if_id_valid`, and a 2-state FSM {RUN, HALTED}.
- Reset values while `rst`=1, applied immediately and asynchronously:
  - `pc`=RESET_PC, so `imem_addr`=RESET_PC.
  - `if_id_pc`=0, `if_id_inst`=NOP (32'h0000_0013, addi x0,x0,0), `if_id_valid`=0.
  - FSM=RUN, `halted`=0.
- Per-edge priority: `pc_src` > `stall` > state action.
- Redirect (`pc_src`=1), in any state:
  - `pc` ← {branch_target[31:2], 2'b00}.
  - `if_id_inst` ← NOP, `if_id_valid` ← 0, `if_id_pc` ← 0.
  - FSM ← RUN.
  - The redirect wins over a simultaneous `stall`.
- Stall (`stall`=1, `pc_src`=0): `pc`, the IF/ID register and the FSM all hold.
- RUN, no stall, no redirect:
  - `if_id_inst` ← `imem_data`, `if_id_pc` ← `pc`, `if_id_valid` ← 1.
  - If `imem_data`==ECALL (32'h0000_0073): `pc` holds and FSM ← HALTED.
  - Otherwise: `pc` ← `pc`+4.
- HALTED, no stall, no redirect:
  - `pc` holds.
  - `if_id_inst` ← NOP, `if_id_valid` ← 0, `if_id_pc` ← 0.
  - The ECALL therefore issues exactly once, followed by bubbles.
- Arithmetic: `pc`+4 is a 32-bit unsigned add that wraps modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000. `pc`[1:0] is always 00.
- `halted` = (FSM==HALTED), decoded from the registered state.

## Timing
- `imem_addr` is combinational from the `pc` register, with no logic between them.
- Fetch latency: the instruction at address A appears on `if_id_inst` one edge after the cycle in which `pc`==A, provided that cycle has no stall and no redirect.
- Redirect penalty:
  - Cycle of `pc_src`: the in-flight fetch is discarded.
  - Next cycle: `if_id_valid`=0 and `imem_addr`=target.
  - One cycle later: the target instruction is in IF/ID.
- Stall of N cycles: all outputs are held stable for N cycles, then the sequence resumes with no instruction lost or duplicated.
- Reset mid-operation: all state returns to reset values asynchronously. The first fetch after reset deassertion is from RESET_PC.
- ECALL plus stall in the same cycle: the stall wins. The ECALL is captured on the first unstalled edge.

## Structure
- Shared package (`riscv_pkg`), shared with decode and the immediate generator:
  - `NOP_INST`, `ECALL_INST`.
  - Opcode constants.
  - `fetch_state_t` enum {RUN, HALTED}.
- Sub-module: `if_id_reg`, holding the pipeline register with load, flush and hold controls plus the async reset to NOP/0. `fetch_stage` contains the PC register, the next-PC mux and the FSM.

## Test plan
- Reset: assert `rst` mid-run → `imem_addr`=0, `if_id_inst`=32'h0000_0013 and `if_id_valid`=0 immediately; after deassertion, fetches from 0, 4, 8 appear in IF/ID on successive edges.
- Stall: `stall`=1 for 3 cycles while `pc`=8 → `imem_addr`=8 and `if_id_pc`=4 held for 3 cycles; after release, `if_id_pc` advances 8, 12.
- Redirect plus stall: `pc_src`=1, `stall`=1, `branch_target`=32'h0000_0043 → next cycle `imem_addr`=32'h40 and `if_id_valid`=0; one cycle later `if_id_pc`=32'h40.
- Wrap: RESET_PC=32'hFFFF_FFF8 → `imem_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- ECALL halt: memory word 32'h0000_0073 at address 12 → `if_id_inst`=32'h73 once; `halted`=1; `imem_addr` stays 12; `if_id_valid`=0 on every following cycle.
- Halt exit: while halted, `pc_src`=1 with target 32'h100 → `halted`=0 and `imem_addr`=32'h100 next cycle; normal fetch resumes.
